fetch_ctrl: RTL and testbench

- Instruction-fetch control stage placed directly around the program-counter register.
- Consumes the registered PC value (PcOutput) and produces the next-PC value (PcInput) every cycle.
- Issues word-addressed requests to a variable-latency instruction memory and buffers returned instructions, tagged with their PC, in a 2-entry queue for decode.
- Handles branch redirects, flushing and halt.

---
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control around the PC register: next-PC, imem requests,
// tag queue for in-flight PCs, 2-entry decode queue, redirect/drop, halt.
// Ports: Clk/Rst; PcOutput in, PcInput out; Imem* request/response;
// Instr*/InstrReady decode handshake; BranchTaken/BranchTarget; Halt.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001,
  parameter int          DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] PcOutput,
  output logic [15:0] PcInput,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [15:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [15:0] ImemRspData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [15:0] Instr,
  output logic [15:0] InstrPc,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic        Halt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW+1:0] LIMIT = (CW+2)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tag_q [DEPTH];
  logic [15:0]   tag_d [DEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;
  logic [15:0]   iq_data_q [DEPTH];
  logic [15:0]   iq_data_d [DEPTH];
  logic [15:0]   iq_pc_q [DEPTH];
  logic [15:0]   iq_pc_d [DEPTH];
  logic [AW-1:0] iq_wr_q, iq_wr_d;
  logic [AW-1:0] iq_rd_q, iq_rd_d;

  logic [CW+1:0] busy;
  logic          hs;
  logic          rsp_drop;
  logic          rsp_take;
  logic          iq_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign ImemAddr = PcOutput;
  assign Instr    = iq_data_q[iq_rd_q];
  assign InstrPc  = iq_pc_q[iq_rd_q];

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    iq_data_d = iq_data_q;
    iq_pc_d   = iq_pc_q;
    iq_wr_d   = iq_wr_q;
    iq_rd_d   = iq_rd_q;

    // drop, outstanding and buffered all share the DEPTH budget
    busy = (CW+2)'(drop_q) + (CW+2)'(out_q) + (CW+2)'(cnt_q);
    ImemReqValid = (state_q == RUN) && (busy < LIMIT) && !BranchTaken;
    hs = ImemReqValid && ImemReqReady;
    InstrValid = (cnt_q != '0);
    // a response with nothing outstanding is stale (e.g. after reset)
    rsp_drop = ImemRspValid && (drop_q != '0);
    rsp_take = ImemRspValid && (drop_q == '0) && (out_q != '0);
    iq_pop = InstrValid && InstrReady && !BranchTaken;

    if (Rst) PcInput = RESET_PC;
    else if (BranchTaken) PcInput = BranchTarget;
    else if (state_q == BOOT) PcInput = RESET_PC;
    else if (hs) PcInput = PcOutput + PC_STEP;
    else PcInput = PcOutput;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: if (Halt && !BranchTaken) state_d = HALTED;
      HALTED: if (BranchTaken) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (BranchTaken) begin
      // every in-flight response becomes a drop; one taken now is discarded
      drop_d   = drop_q - CW'(rsp_drop) + out_q - CW'(rsp_take);
      out_d    = '0;
      cnt_d    = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
      iq_wr_d  = '0;
      iq_rd_d  = '0;
    end else begin
      if (hs) begin
        tag_d[tag_wr_q] = PcOutput;
        tag_wr_d = nxt(tag_wr_q);
      end
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (rsp_take) begin
        iq_data_d[iq_wr_q] = ImemRspData;
        iq_pc_d[iq_wr_q]   = tag_q[tag_rd_q];
        iq_wr_d  = nxt(iq_wr_q);
        tag_rd_d = nxt(tag_rd_q);
      end
      if (iq_pop) iq_rd_d = nxt(iq_rd_q);
      out_d = out_q + CW'(hs) - CW'(rsp_take);
      cnt_d = cnt_q + CW'(rsp_take) - CW'(iq_pop);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= BOOT;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      tag_q     <= '{default: '0};
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      iq_data_q <= '{default: '0};
      iq_pc_q   <= '{default: '0};
      iq_wr_q   <= '0;
      iq_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      iq_data_q <= iq_data_d;
      iq_pc_q   <= iq_pc_d;
      iq_wr_q   <= iq_wr_d;
      iq_rd_q   <= iq_rd_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and in-order variable-latency memory
// models, expected-fetch scoreboard, per-cycle vector table, corner cases.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        Rst;
  logic [15:0] PcOutput;
  logic [15:0] PcInput;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [15:0] ImemAddr;
  logic        ImemRspValid;
  logic [15:0] ImemRspData;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] Instr;
  logic [15:0] InstrPc;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        Halt;

  fetch_ctrl #(
    .RESET_PC(16'h0000),
    .PC_STEP (16'h0001),
    .DEPTH   (DEPTH)
  ) dut (
    .Clk         (clk),
    .Rst         (Rst),
    .PcOutput    (PcOutput),
    .PcInput     (PcInput),
    .ImemReqValid(ImemReqValid),
    .ImemReqReady(ImemReqReady),
    .ImemAddr    (ImemAddr),
    .ImemRspValid(ImemRspValid),
    .ImemRspData (ImemRspData),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instr       (Instr),
    .InstrPc     (InstrPc),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Halt        (Halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rst;
    logic        ir;
    logic        req;
    logic [15:0] pcin;
    logic        iv;
    logic [15:0] ipc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;
  int n_pop = 0;
  logic [15:0] exp_q[$];
  mreq_t       mem_q[$];
  logic [15:0] last_pop_pc;

  logic        s_req, s_hs, s_iv;
  logic [15:0] s_addr, s_pcin, s_ipc, s_instr, s_pc;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] e;
    mreq_t m;
    @(negedge clk);
    s_req   = ImemReqValid;
    s_addr  = ImemAddr;
    s_pcin  = PcInput;
    s_iv    = InstrValid;
    s_ipc   = InstrPc;
    s_instr = Instr;
    s_pc    = PcOutput;
    s_hs    = ImemReqValid && ImemReqReady && !Rst;
    if (Rst) begin
      exp_q.delete();
      mem_q.delete();
      last_due = cyc;
    end else begin
      if (InstrValid && InstrReady && !BranchTaken) begin
        n_pop++;
        last_pop_pc = InstrPc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h, expected none", InstrPc);
        end else begin
          e = exp_q.pop_front();
          check16("instr_pc", InstrPc, e);
          check16("instr_data", Instr, mdata(e));
        end
      end
      if (BranchTaken) exp_q.delete();
      if (s_hs) begin
        exp_q.push_back(s_addr);
        m.addr = s_addr;
        m.due  = cyc + lat;
        if (m.due <= last_due) m.due = last_due + 1;
        last_due = m.due;
        mem_q.push_back(m);
      end
      n_chk++;
      if (exp_q.size() > DEPTH) begin
        n_fail++;
        $display("FAIL overflow: got %0d entries, expected <= %0d",
                 exp_q.size(), DEPTH);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    PcOutput = s_pcin;
    ImemRspValid = 1'b0;
    ImemRspData = 16'h0000;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      ImemRspValid = 1'b1;
      ImemRspData = mdata(m.addr);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    BranchTaken = 1'b0;
    Halt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    Rst = 1'b0;
  endtask

  task automatic branch(input logic [15:0] tgt);
    BranchTaken = 1'b1;
    BranchTarget = tgt;
    tick();
    BranchTaken = 1'b0;
  endtask

  task automatic wait_hs(input int budget, input string name,
                         input logic [15:0] exp_a);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (s_hs) got = 1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no request, expected addr %h", name, exp_a);
    end else check16(name, s_addr, exp_a);
  endtask

  task automatic wait_pop(input int budget, input string name,
                          input logic [15:0] exp_pc);
    int p0 = n_pop;
    for (int i = 0; i < budget && n_pop == p0; i++) tick();
    if (n_pop == p0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no instruction, expected pc %h", name, exp_pc);
    end else check16(name, last_pop_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[13];
    logic [15:0] nx;
    int p0;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001};
    vt[10] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    vt[11] = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vt[12] = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003};

    Rst = 1'b0;
    PcOutput = 16'h0000;
    ImemReqReady = 1'b1;
    ImemRspValid = 1'b0;
    ImemRspData = 16'h0000;
    InstrReady = 1'b0;
    BranchTaken = 1'b0;
    BranchTarget = 16'h0000;
    Halt = 1'b0;
    lat = 1;
    #1 Rst = 1'b1;
    @(posedge clk);
    #1;

    // boot + backpressure, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      Rst = vt[i].rst;
      InstrReady = vt[i].ir;
      tick();
      check16($sformatf("v%0d_req", i), 16'(s_req), 16'(vt[i].req));
      check16($sformatf("v%0d_pcin", i), s_pcin, vt[i].pcin);
      check16($sformatf("v%0d_iv", i), 16'(s_iv), 16'(vt[i].iv));
      if (vt[i].req) check16($sformatf("v%0d_addr", i), s_addr, s_pc);
      if (vt[i].iv) check16($sformatf("v%0d_ipc", i), s_ipc, vt[i].ipc);
      if (vt[i].rst) begin
        check16($sformatf("v%0d_rst_ipc", i), s_ipc, 16'h0000);
        check16($sformatf("v%0d_rst_instr", i), s_instr, 16'h0000);
      end
    end

    // streaming continues from address 5
    nx = 16'h0005;
    p0 = n_pop;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_hs) begin
        check16("stream_addr", s_addr, nx);
        nx = nx + 16'h0001;
      end
    end
    n_chk++;
    if (n_pop - p0 < 10) begin
      n_fail++;
      $display("FAIL stream_pops: got %0d, expected >= 10", n_pop - p0);
    end

    // redirect with two requests in flight, latency 3
    lat = 3;
    InstrReady = 1'b1;
    do_reset();
    tick();
    branch(16'h0004);
    wait_hs(10, "redir_a4", 16'h0004);
    wait_hs(10, "redir_a5", 16'h0005);
    branch(16'h0040);
    check16("redir_noreq", 16'(s_req), 16'h0000);
    tick();
    check16("redir_empty", 16'(s_iv), 16'h0000);
    wait_hs(10, "redir_target", 16'h0040);
    wait_pop(10, "redir_first_pc", 16'h0040);

    // redirect in the same cycle as an accepted response
    lat = 2;
    do_reset();
    for (int i = 0; i < 20 && !ImemRspValid; i++) tick();
    check16("coll_rsp_seen", 16'(ImemRspValid), 16'h0001);
    branch(16'h0020);
    check16("coll_noreq", 16'(s_req), 16'h0000);
    wait_pop(20, "coll_first_pc", 16'h0020);
    wait_pop(20, "coll_second_pc", 16'h0021);

    // wrap at 16'hFFFF, then halt, drain, and resume
    lat = 1;
    do_reset();
    tick();
    branch(16'hFFFF);
    wait_hs(10, "wrap_ffff", 16'hFFFF);
    wait_hs(10, "wrap_0000", 16'h0000);
    Halt = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check16("halt_noreq", 16'(s_req), 16'h0000);
      check16("halt_hold", s_pcin, s_pc);
    end
    check16("halt_drained", 16'(exp_q.size()), 16'h0000);
    check16("halt_iv", 16'(s_iv), 16'h0000);
    Halt = 1'b0;
    branch(16'h0010);
    wait_hs(10, "resume_0010", 16'h0010);
    wait_pop(10, "resume_pc", 16'h0010);

    // random traffic with redirects
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 300; i++) begin
      ImemReqReady = ($urandom_range(0, 3) != 0);
      InstrReady = ($urandom_range(0, 2) != 0);
      lat = $urandom_range(1, 4);
      BranchTaken = ($urandom_range(0, 19) == 0);
      BranchTarget = 16'($urandom);
      tick();
    end
    BranchTaken = 1'b0;
    n_chk++;
    if (n_pop - p0 < 20) begin
      n_fail++;
      $display("FAIL rand_pops: got %0d, expected >= 20", n_pop - p0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
